// File: rtl/add_sub32.sv
// Registered 32-bit adder/subtractor built from 4-bit carry-lookahead blocks.
// Optional signed-overflow output V is compiled in with ADD_SUB_32_OVF_EN.
module add_sub32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Ci,
  input  logic        Subtract,
  output logic [31:0] S,
  output logic        Co
`ifdef ADD_SUB_32_OVF_EN
  ,
  output logic        V
`endif
);

  logic [31:0] b_eff;
  logic [31:0] gen;
  logic [31:0] prop;
  logic [32:0] carry;
  logic [31:0] s_d, s_q;
  logic        co_d, co_q;

  always_comb begin
    b_eff    = B ^ {32{Subtract}};
    gen      = A & b_eff;
    prop     = A ^ b_eff;
    carry    = '0;
    carry[0] = Ci ^ Subtract;
    // Each block derives its internal carries from the block carry-in only.
    for (int unsigned blk = 0; blk < 8; blk++) begin
      carry[4*blk+1] = gen[4*blk] | (prop[4*blk] & carry[4*blk]);
      carry[4*blk+2] = gen[4*blk+1]
                     | (prop[4*blk+1] & gen[4*blk])
                     | (prop[4*blk+1] & prop[4*blk] & carry[4*blk]);
      carry[4*blk+3] = gen[4*blk+2]
                     | (prop[4*blk+2] & gen[4*blk+1])
                     | (prop[4*blk+2] & prop[4*blk+1] & gen[4*blk])
                     | (prop[4*blk+2] & prop[4*blk+1] & prop[4*blk] & carry[4*blk]);
      carry[4*blk+4] = gen[4*blk+3]
                     | (prop[4*blk+3] & gen[4*blk+2])
                     | (prop[4*blk+3] & prop[4*blk+2] & gen[4*blk+1])
                     | (prop[4*blk+3] & prop[4*blk+2] & prop[4*blk+1] & gen[4*blk])
                     | (prop[4*blk+3] & prop[4*blk+2] & prop[4*blk+1] & prop[4*blk]
                        & carry[4*blk]);
    end
    s_d  = prop ^ carry[31:0];
    co_d = carry[32];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q  <= '0;
      co_q <= 1'b0;
    end else begin
      s_q  <= s_d;
      co_q <= co_d;
    end
  end

  assign S  = s_q;
  assign Co = co_q;

`ifdef ADD_SUB_32_OVF_EN
  logic v_d, v_q;

  always_comb v_d = carry[31] ^ carry[32];

  always_ff @(posedge clk) begin
    if (!rst_n) v_q <= 1'b0;
    else        v_q <= v_d;
  end

  assign V = v_q;
`endif

endmodule

// File: tb/tb_add_sub32.sv
// Directed self-checking bench for add_sub32: hand vectors, then a reference-model stream.
module tb_add_sub32;

  logic        clk;
  logic        rst_n;
  logic [31:0] A, B;
  logic        Ci, Subtract;
  logic [31:0] S;
  logic        Co;
`ifdef ADD_SUB_32_OVF_EN
  logic        V;
`endif

  int errors = 0;
  int checks = 0;

  add_sub32 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (A),
    .B        (B),
    .Ci       (Ci),
    .Subtract (Subtract),
    .S        (S),
    .Co       (Co)
`ifdef ADD_SUB_32_OVF_EN
    ,
    .V        (V)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [32:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic ci, input logic sub);
    logic [32:0] r;
    if (!sub) begin
      r = {1'b0, a} + {1'b0, b} + {32'd0, ci};
    end else begin
      r = {1'b0, a} - {1'b0, b} - {32'd0, ci};
      r[32] = ~r[32];
    end
    return r;
  endfunction

  task automatic apply(input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic sub);
    A = a; B = b; Ci = ci; Subtract = sub;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] s_exp, input logic co_exp);
    checks++;
    assert (S === s_exp) else begin
      errors++;
      $error("FAIL %s S: got %h expected %h", tag, S, s_exp);
    end
    checks++;
    assert (Co === co_exp) else begin
      errors++;
      $error("FAIL %s Co: got %b expected %b", tag, Co, co_exp);
    end
  endtask

`ifdef ADD_SUB_32_OVF_EN
  task automatic check_v(input string tag, input logic v_exp);
    checks++;
    assert (V === v_exp) else begin
      errors++;
      $error("FAIL %s V: got %b expected %b", tag, V, v_exp);
    end
  endtask
`endif

  initial begin
    logic [32:0] exp;
    rst_n = 1'b0;
    A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; Ci = 1'b1; Subtract = 1'b0;
    @(posedge clk);
    #1;
    check("reset", 32'h0, 1'b0);
`ifdef ADD_SUB_32_OVF_EN
    check_v("reset", 1'b0);
`endif
    rst_n = 1'b1;

    apply(32'd10, 32'd20, 1'b0, 1'b0);
    check("add_basic", 32'd30, 1'b0);
    apply(32'd10, 32'd20, 1'b1, 1'b0);
    check("add_basic_ci", 32'd31, 1'b0);
    apply(32'd10, 32'd20, 1'b0, 1'b1);
    check("sub_neg", 32'hFFFF_FFF6, 1'b0);
`ifdef ADD_SUB_32_OVF_EN
    check_v("sub_neg", 1'b0);
`endif
    apply(32'd10, 32'd20, 1'b1, 1'b1);
    check("sub_neg_ci", 32'hFFFF_FFF5, 1'b0);
    apply(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    check("carry_wrap", 32'h0, 1'b1);
    apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    check("carry_max", 32'hFFFF_FFFF, 1'b1);
    apply(32'h0, 32'h0, 1'b0, 1'b1);
    check("borrow_zero", 32'h0, 1'b1);
    apply(32'h0, 32'h0, 1'b1, 1'b1);
    check("borrow_ci", 32'hFFFF_FFFF, 1'b0);
    apply(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0);
    check("add_mixed", 32'hACF1_3568, 1'b0);
    apply(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    check("ovf_add", 32'h8000_0000, 1'b0);
`ifdef ADD_SUB_32_OVF_EN
    check_v("ovf_add", 1'b1);
`endif
    apply(32'h8000_0000, 32'h1, 1'b0, 1'b1);
    check("ovf_sub", 32'h7FFF_FFFF, 1'b1);
`ifdef ADD_SUB_32_OVF_EN
    check_v("ovf_sub", 1'b1);
`endif

    // Stream: Ci toggles every 20 time units, Subtract every 80, reset pulse mid-stream.
    for (int c = 0; c < 48; c++) begin
      logic [31:0] a, b;
      logic ci, sub;
      a = $urandom;
      b = (c % 7 == 3) ? a : $urandom;
      ci = logic'((c / 2) % 2);
      sub = logic'((c / 8) % 2);
      rst_n = (c == 24) ? 1'b0 : 1'b1;
      exp = (c == 24) ? 33'd0 : ref_model(a, b, ci, sub);
      apply(a, b, ci, sub);
      check((c == 24) ? "stream_reset" : "stream", exp[31:0], exp[32]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded 20000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/add_sub32.md
# add_sub32

Registered 32-bit adder/subtractor with carry/borrow in and carry/borrow out. Each rising clock edge samples two 32-bit operands, a carry input and a mode select, and registers the sum or difference together with the carry-out. It serves as a standalone arithmetic datapath element, built from explicit full-adder/carry logic rather than a single behavioural `+`.

## Interface
- No parameters; width fixed at 32 bits.
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- A  input  32  operand A, unsigned or two's complement.
- B  input  32  operand B.
- Ci  input  1  carry-in in add mode; borrow-in in subtract mode.
- Subtract  input  1  0 = add, 1 = subtract.
- S  output  32  registered result.
- Co  output  1  registered carry-out in add mode; inverted borrow in subtract mode (1 = no borrow).
- V  output  1  registered signed-overflow flag; present only with ADD_SUB_32_OVF_EN.

## Operation
- Add (Subtract=0): {Co,S} = A + B + Ci, a 33-bit unsigned result.
- Subtract (Subtract=1): {Co,S} = A + ~B + ~Ci, which equals A − B − Ci modulo 2^32.
  - Co=1 means no borrow (A ≥ B + Ci, unsigned).
  - Co=0 means borrow.
- Datapath structure:
  - Operand-B conditioning: B_eff = B XOR {32{Subtract}}.
  - Carry-in conditioning: c0 = Ci XOR Subtract.
  - Adder: 32-bit ripple or 4-bit-block carry-lookahead built from full-adder cells.
  - Carry-out of bit 31 is Co.
- Result wraps modulo 2^32; no saturation.
- Overflow (when compiled in): V = carry into bit 31 XOR carry out of bit 31.
- All outputs come only from registers; there are no combinational input-to-output paths.

## Timing
- Latency 1 cycle: inputs present at rising edge N appear on S/Co/V after edge N and remain stable until edge N+1.
- Throughput: one operation per cycle; no handshake and no stall.
- Reset: when rst_n=0 at a rising edge, S=0, Co=0 and V=0, regardless of the other inputs.
  - Reset takes priority over computation.
  - Asserting reset mid-stream discards the in-flight result.
  - The first valid result appears one edge after the edge where rst_n is sampled high.
- Outputs are undefined before the first clock edge; they are defined from the first reset edge onward.
- Mode or Ci changes take effect on the next edge; there is no cross-cycle state between operations.

## Configuration
- Macro: ADD_SUB_32_OVF_EN.
- Defined: output port V exists and is registered as described in Operation; it resets to 0.
- Undefined: V port and its register are absent; S/Co behaviour is identical in both builds.

## Test plan
- Add basic: A=10, B=20, Subtract=0, Ci=0 → after one edge S=30, Co=0; with Ci=1 → S=31, Co=0.
- Subtract negative result: A=10, B=20, Subtract=1, Ci=0 → S=0xFFFFFFF6, Co=0; with Ci=1 → S=0xFFFFFFF5, Co=0.
- Carry wrap: A=0xFFFFFFFF, B=0, Ci=1, Subtract=0 → S=0, Co=1; A=0xFFFFFFFF, B=0xFFFFFFFF, Ci=1 → S=0xFFFFFFFF, Co=1.
- Borrow boundary: Subtract=1, A=0, B=0, Ci=0 → S=0, Co=1; with Ci=1 → S=0xFFFFFFFF, Co=0.
- Overflow (ADD_SUB_32_OVF_EN): A=0x7FFFFFFF, B=1, add, Ci=0 → S=0x80000000, V=1; A=0x80000000, B=1, subtract, Ci=0 → S=0x7FFFFFFF, V=1; A=10, B=20 subtract → V=0.
- Reset and latency: run the stimulus stream with clk period 10, toggle Ci every 20 and Subtract every 80, then assert rst_n=0 for one edge → S=0, Co=0 on that edge. Afterwards, each output equals the reference model applied to the inputs sampled at the previous edge.
